// File: rtl/serial_add_sub.sv
// rtl/serial_add_sub.sv - digit-serial adder/subtractor with start/busy/done handshake
// Consumes DIGIT operand bits per clock, LSB digit first; carry lives in a register between steps.
module serial_add_sub #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STEPS = WIDTH / DIGIT;
   localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

   generate
      if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
         $error("serial_add_sub: DIGIT must be >= 1 and divide WIDTH exactly");
      end
   endgenerate

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] acc;
   logic             carry;
   logic [CW-1:0]    cnt;

   logic [DIGIT:0]   dadd;
   logic [DIGIT-1:0] dsum;
   logic             dcout;
   logic             dc_msb;
   logic             d_ovf;
   logic             last_step;
   logic [WIDTH-1:0] sa_next;
   logic [WIDTH-1:0] sb_next;
   logic [WIDTH-1:0] acc_next;

   // One digit of the ripple chain; the carry into its top bit is recovered from the sum bit.
   always_comb begin
      dadd   = {1'b0, sa[DIGIT-1:0]} + {1'b0, sb[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
      dsum   = dadd[DIGIT-1:0];
      dcout  = dadd[DIGIT];
      dc_msb = dsum[DIGIT-1] ^ sa[DIGIT-1] ^ sb[DIGIT-1];
      d_ovf  = dc_msb ^ dcout;
   end

   assign last_step = (cnt == CW'(STEPS - 1));

   generate
      if (DIGIT == WIDTH) begin : g_single_step
         assign sa_next  = '0;
         assign sb_next  = '0;
         assign acc_next = dsum;
      end else begin : g_multi_step
         assign sa_next  = {{DIGIT{1'b0}}, sa[WIDTH-1:DIGIT]};
         assign sb_next  = {{DIGIT{1'b0}}, sb[WIDTH-1:DIGIT]};
         assign acc_next = {dsum, acc[WIDTH-1:DIGIT]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sa    <= '0;
         sb    <= '0;
         acc   <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sa    <= a;
                  sb    <= sub ? ~b : b;
                  carry <= sub;
                  cnt   <= '0;
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               sa    <= sa_next;
               sb    <= sb_next;
               acc   <= acc_next;
               carry <= dcout;
               cnt   <= cnt + CW'(1);
               if (last_step) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  sum   <= acc_next;
                  cout  <= dcout;
                  ovf   <= d_ovf;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// tb/tb_serial_add_sub.sv - checks serial_add_sub at DIGIT=1/4/8 against an arithmetic model
module tb_serial_add_sub;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start0 = 1'b0;
   logic       start_o = 1'b0;
   logic       sub = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;

   logic       busy [3];
   logic       done [3];
   logic       cout [3];
   logic       ovf  [3];
   logic [7:0] sum  [3];

   int checks = 0;
   int errors = 0;

   serial_add_sub #(.WIDTH(8), .DIGIT(1)) u_d1 (
      .clk(clk), .rst_n(rst_n), .start(start0), .sub(sub), .a(a), .b(b),
      .busy(busy[0]), .done(done[0]), .sum(sum[0]), .cout(cout[0]), .ovf(ovf[0]));
   serial_add_sub #(.WIDTH(8), .DIGIT(4)) u_d4 (
      .clk(clk), .rst_n(rst_n), .start(start_o), .sub(sub), .a(a), .b(b),
      .busy(busy[1]), .done(done[1]), .sum(sum[1]), .cout(cout[1]), .ovf(ovf[1]));
   serial_add_sub #(.WIDTH(8), .DIGIT(8)) u_d8 (
      .clk(clk), .rst_n(rst_n), .start(start_o), .sub(sub), .a(a), .b(b),
      .busy(busy[2]), .done(done[2]), .sum(sum[2]), .cout(cout[2]), .ovf(ovf[2]));

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] va;
      logic [7:0] vb;
      logic       vsub;
      logic [7:0] esum;
      logic       ecout;
      logic       eovf;
   } vec_t;

   vec_t vecs[8];

   function automatic int steps_of(input int i);
      return (i == 0) ? 8 : ((i == 1) ? 2 : 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void model(input logic [7:0] x, input logic [7:0] y, input logic s,
                                 output logic [7:0] rs, output logic rc, output logic ro);
      int xi, yi, r, xs, ys, q;
      xi = x;
      yi = y;
      xs = $signed(x);
      ys = $signed(y);
      if (s) begin
         r  = xi - yi;
         rc = (xi >= yi);
         q  = xs - ys;
      end else begin
         r  = xi + yi;
         rc = (r > 255);
         q  = xs + ys;
      end
      rs = r[7:0];
      ro = (q > 127) || (q < -128);
   endfunction

   // Start all three instances together; mid=1 also scrambles inputs and re-pulses start on the DIGIT=1 one.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tbv, input logic ts,
                         input logic [7:0] es, input logic ec, input logic eo,
                         input bit mid, input string nm);
      logic [7:0] s_cap [3];
      logic       c_cap [3];
      logic       o_cap [3];
      int         lat   [3];
      int         extra [3];
      bit         busy_ok;
      int         ncyc;
      for (int i = 0; i < 3; i++) begin
         lat[i] = 0; extra[i] = 0; s_cap[i] = 'x; c_cap[i] = 1'bx; o_cap[i] = 1'bx;
      end
      busy_ok = 1'b1;
      ncyc = mid ? 20 : 11;
      a = ta; b = tbv; sub = ts; start0 = 1'b1; start_o = 1'b1;
      for (int k = 1; k <= ncyc; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            start0 = 1'b0;
            start_o = 1'b0;
         end
         if (mid) begin
            a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
            start0 = (k == 3);
         end
         if (busy[0] !== (k <= 8)) busy_ok = 1'b0;
         for (int i = 0; i < 3; i++) begin
            if (done[i] === 1'b1) begin
               if (lat[i] == 0) begin
                  lat[i] = k; s_cap[i] = sum[i]; c_cap[i] = cout[i]; o_cap[i] = ovf[i];
               end else begin
                  extra[i]++;
               end
            end
         end
      end
      for (int i = 0; i < 3; i++) begin
         check($sformatf("%s s%0d done_latency", nm, steps_of(i)), lat[i], steps_of(i) + 1);
         check($sformatf("%s s%0d sum", nm, steps_of(i)), s_cap[i], es);
         check($sformatf("%s s%0d cout", nm, steps_of(i)), c_cap[i], ec);
         check($sformatf("%s s%0d ovf", nm, steps_of(i)), o_cap[i], eo);
         check($sformatf("%s s%0d extra_done", nm, steps_of(i)), extra[i], 0);
      end
      check($sformatf("%s busy_window", nm), busy_ok, 1);
   endtask

   initial begin
      logic [7:0] rs;
      logic       rc, ro;
      bit         hold_ok;
      int         ndone;

      vecs[0] = '{8'd100, 8'd55,  1'b0, 8'd155, 1'b0, 1'b1};
      vecs[1] = '{8'd200, 8'd100, 1'b0, 8'd44,  1'b1, 1'b0};
      vecs[2] = '{8'd5,   8'd7,   1'b1, 8'd254, 1'b0, 1'b0};
      vecs[3] = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};
      vecs[4] = '{8'h00,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0};
      vecs[5] = '{8'h7F,  8'hFF,  1'b1, 8'h80,  1'b0, 1'b1};
      vecs[6] = '{8'h7F,  8'h01,  1'b0, 8'h80,  1'b0, 1'b1};
      vecs[7] = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};

      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("reset s%0d busy", steps_of(i)), busy[i], 0);
         check($sformatf("reset s%0d done", steps_of(i)), done[i], 0);
         check($sformatf("reset s%0d sum", steps_of(i)), sum[i], 0);
         check($sformatf("reset s%0d cout", steps_of(i)), cout[i], 0);
         check($sformatf("reset s%0d ovf", steps_of(i)), ovf[i], 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 8; v++)
         run_op(vecs[v].va, vecs[v].vb, vecs[v].vsub, vecs[v].esum, vecs[v].ecout, vecs[v].eovf,
                1'b0, $sformatf("vec%0d", v));

      // Abort a DIGIT=1 run at step 4 while the previous result (0x7F, cout=1, ovf=1) is still showing.
      a = 8'd9; b = 8'd3; sub = 1'b0; start0 = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         if (k == 1) start0 = 1'b0;
      end
      rst_n = 1'b0;
      #1;
      check("abort busy", busy[0], 0);
      check("abort done", done[0], 0);
      check("abort sum", sum[0], 0);
      check("abort cout", cout[0], 0);
      check("abort ovf", ovf[0], 0);
      check("abort s8 sum", sum[2], 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ndone = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done[0] === 1'b1) ndone++;
      end
      check("abort no_done", ndone, 0);
      check("abort idle_busy", busy[0], 0);
      run_op(8'd9, 8'd3, 1'b0, 8'd12, 1'b0, 1'b0, 1'b0, "after_abort");

      run_op(8'd100, 8'd55, 1'b0, 8'd155, 1'b0, 1'b1, 1'b1, "midrun");

      // Second start issued during the done cycle of the first.
      a = 8'd100; b = 8'd55; sub = 1'b0; start0 = 1'b1;
      hold_ok = 1'b1;
      for (int k = 1; k <= 18; k++) begin
         @(posedge clk); #1;
         if (k == 1) start0 = 1'b0;
         if (k == 9) begin
            check("b2b first done", done[0], 1);
            check("b2b first sum", sum[0], 155);
            a = 8'd1; b = 8'd1; sub = 1'b0; start0 = 1'b1;
         end
         if (k == 10) begin
            start0 = 1'b0; a = 8'hAA; b = 8'h55; sub = 1'b1;
         end
         if (k >= 10 && k <= 17 && (done[0] !== 1'b0 || sum[0] !== 8'd155 || busy[0] !== 1'b1))
            hold_ok = 1'b0;
         if (k == 18) begin
            check("b2b second done", done[0], 1);
            check("b2b second sum", sum[0], 2);
            check("b2b second cout", cout[0], 0);
            check("b2b second ovf", ovf[0], 0);
         end
      end
      check("b2b hold_between", hold_ok, 1);
      @(posedge clk); #1;

      for (int n = 0; n < 1000; n++) begin
         logic [7:0] ra, rb;
         logic       rsb;
         ra = 8'($urandom); rb = 8'($urandom); rsb = 1'($urandom);
         model(ra, rb, rsb, rs, rc, ro);
         run_op(ra, rb, rsb, rs, rc, ro, 1'b0, $sformatf("rnd%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
